// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and helpers for the multi-digit BCD up/down counter.
package bcd_updown_counter_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  // Any nibble above 9 is forced to 9 so the register only ever holds BCD.
  function automatic bcd_t bcd_clamp(input bcd_t v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One BCD digit of the cascaded counter: registered value plus carry/borrow out.
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  bcd_t load_nib,
  input  logic step_in,
  input  logic updown,
  input  logic hold,
  output bcd_t digit,
  output logic step_out
);

  bcd_t digit_q;
  bcd_t digit_d;

  // Next value when this digit is asked to step up or down.
  always_comb begin
    digit_d = digit_q;
    if (step_in && !hold) begin
      if (updown) begin
        digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  // Digit register: reset, then load, then step/hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      digit_q <= BCD_MIN;
    end else if (load) begin
      digit_q <= load_nib;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit    = digit_q;
  assign step_out = step_in & (updown ? (digit_q == BCD_MAX) : (digit_q == BCD_MIN));

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit up/down BCD counter with enable, clamped parallel load and a
// registered terminal-count pulse. Define BCD_SATURATE_EN to saturate at the
// limits instead of wrapping.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        updown,
  input  logic                        load,
  input  logic [DIGIT_W*DIGITS-1:0]   load_val,
  output logic [DIGIT_W*DIGITS-1:0]   c_out,
  output logic                        tc
);

  logic [DIGITS:0] step;
  logic            hold;
  logic            tc_q;
  logic            tc_d;

  assign step[0] = en;

  // Carry out of the last digit means every digit sits at the limit for the
  // current direction with en high: the terminal condition in both builds.
  assign tc_d = step[DIGITS];

`ifdef BCD_SATURATE_EN
  // Freezing every digit at the terminal condition turns wrap into saturate
  // without touching the carry chain that detects it.
  assign hold = step[DIGITS];
`else
  assign hold = 1'b0;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_nib (bcd_clamp(load_val[g*DIGIT_W +: DIGIT_W])),
      .step_in  (step[g]),
      .updown   (updown),
      .hold     (hold),
      .digit    (c_out[g*DIGIT_W +: DIGIT_W]),
      .step_out (step[g+1])
    );
  end

  // Terminal-count register, aligned with the wrapped/held count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tc_q <= 1'b0;
    end else if (load) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign tc = tc_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed self-checking bench for bcd_updown_counter with DIGITS=2.
// Expected values follow the saturating behaviour when BCD_SATURATE_EN is defined.
module tb_bcd_updown_counter;

`ifdef BCD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       updown;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] c_out;
  logic       tc;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  bcd_updown_counter #(.DIGITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .updown   (updown),
    .load     (load),
    .load_val (load_val),
    .c_out    (c_out),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [7:0] c, input logic t);
    check({tag, ".c_out"}, {24'd0, c_out}, {24'd0, c});
    check({tag, ".tc"}, {31'd0, tc}, {31'd0, t});
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v; tick(); load = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; updown = 1'b1; load = 1'b0; load_val = 8'h00;

    // Reset held two cycles with en high.
    tick(); tick();
    expect_state("reset", 8'h00, 1'b0);

    // Count up 1..10 from reset.
    rst = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      expect_state($sformatf("up%0d", i), 8'(((i / 10) << 4) | (i % 10)), 1'b0);
    end

    // Up wrap from 98.
    en = 1'b0;
    do_load(8'h98);
    expect_state("ld98", 8'h98, 1'b0);
    en = 1'b1; updown = 1'b1;
    tick(); expect_state("up99", 8'h99, 1'b0);
    tick(); expect_state("upwrap", SAT ? 8'h99 : 8'h00, 1'b1);
    tick(); expect_state("upafter", SAT ? 8'h99 : 8'h01, SAT);

    // Load clears a pending tc and ignores en.
    do_load(8'h33);
    expect_state("ld_tc_clr", 8'h33, 1'b0);

    // Down wrap from 00.
    do_load(8'h00);
    updown = 1'b0;
    tick(); expect_state("dnwrap", SAT ? 8'h00 : 8'h99, 1'b1);
    tick(); expect_state("dnafter", SAT ? 8'h00 : 8'h98, SAT);
    do_load(8'h10);
    tick(); expect_state("dn10", 8'h09, 1'b0);

    // Load clamp and priority.
    en = 1'b0;
    do_load(8'h5C); expect_state("clamp5C", 8'h59, 1'b0);
    do_load(8'hFA); expect_state("clampFA", 8'h99, 1'b0);
    en = 1'b1; updown = 1'b1;
    do_load(8'h23); expect_state("ld_over_en", 8'h23, 1'b0);
    rst = 1'b0;
    do_load(8'h45); expect_state("rst_over_ld", 8'h00, 1'b0);
    rst = 1'b1;

    // Hold, then alternate direction every cycle.
    en = 1'b0;
    do_load(8'h47);
    for (int i = 0; i < 5; i++) begin
      tick(); expect_state($sformatf("hold%0d", i), 8'h47, 1'b0);
    end
    en = 1'b1;
    updown = 1'b1; tick(); expect_state("alt_up1", 8'h48, 1'b0);
    updown = 1'b0; tick(); expect_state("alt_dn", 8'h47, 1'b0);
    updown = 1'b1; tick(); expect_state("alt_up2", 8'h48, 1'b0);

    // Limit held with en low never raises tc.
    en = 1'b0;
    do_load(8'h99);
    tick(); expect_state("lim_noen", 8'h99, 1'b0);

    // Three enabled up steps from 99.
    en = 1'b1; updown = 1'b1;
    tick(); expect_state("lim1", SAT ? 8'h99 : 8'h00, 1'b1);
    tick(); expect_state("lim2", SAT ? 8'h99 : 8'h01, SAT);
    tick(); expect_state("lim3", SAT ? 8'h99 : 8'h02, SAT);

    // Reset mid-count, then resume.
    rst = 1'b0; tick(); expect_state("midrst", 8'h00, 1'b0);
    rst = 1'b1; tick(); expect_state("resume", 8'h01, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised multi-digit up/down BCD counter, the successor to the single-digit up/down BCD counter. It extends that block to `DIGITS` cascaded decimal digits and adds count enable, synchronous parallel load and a registered terminal-count pulse. It is a Moore-style block: every output comes straight from a register. It is used as a decimal event/time counter feeding display and control logic.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal range 1–8.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous reset, active-low.
- `en`  in  1: count enable; one step per cycle while high.
- `updown`  in  1: 1 = count up, 0 = count down.
- `load`  in  1: synchronous parallel load.
- `load_val`  in  4*DIGITS: load value, one nibble per digit, digit 0 in [3:0].
- `c_out`  out  4*DIGITS: registered BCD count, digit 0 is least significant.
- `tc`  out  1: registered terminal-count pulse.

## Operation
- Priority at each rising edge: `rst`==0, then `load`, then `en`, then hold.
- Reset: `c_out` = 0 (all digits), `tc` = 0.
- Load:
  - Each nibble of `load_val` above 9 is stored as 9. Example: 4'hC becomes 9.
  - `tc` = 0. `en` and `updown` are ignored that cycle.
- Count up (`en`=1, `updown`=1):
  - Digit 0 increments.
  - A digit at 9 that receives a carry goes to 0 and passes the carry to the next digit.
- Count down (`en`=1, `updown`=0):
  - Digit 0 decrements.
  - A digit at 0 that receives a borrow goes to 9 and passes the borrow to the next digit.
- Terminal condition: up at all-9s, or down at all-0s.
  - Wrap mode (default): the count wraps (99…9 to 0, 0 to 99…9) and `tc`=1 for that one cycle.
  - `tc`=0 on every other cycle.
- `en`=0 with `load`=0: count holds and `tc`=0.
- A direction change takes effect on the next enabled edge. There is no turnaround cycle.
- The count register never holds a non-BCD digit under any input sequence.

## Timing
- Latency is one cycle. Inputs sampled at edge N appear on `c_out`/`tc` after edge N.
- `tc` is aligned with the wrapped value. It is high in the same cycle `c_out` shows the wrapped value.
- There are no combinational paths from inputs to outputs.
- The ripple carry chain spans DIGITS × 4-bit stages within one cycle.
- Reset mid-count: at the edge with `rst`=0 the count is cleared, and counting resumes on the first edge with `rst`=1 and `en`=1.
- If `rst`=0 and `load`=1 arrive together, reset wins.

## Configuration
- Macro name: `BCD_SATURATE_EN`.
- Defined: the counter saturates instead of wrapping.
  - At all-9s with up, or all-0s with down, with `en`=1, the count holds.
  - `tc`=1 on every such cycle in which the count is held at the limit.
- Undefined: wrap behaviour as described in Operation.
- Load, reset and the interface are identical in both builds.

## Structure
- Shared package/include holds:
  - `BCD_MAX` = 4'd9 and `BCD_MIN` = 4'd0.
  - The digit width constant, 4.
- Sub-module `bcd_digit`, one instance per digit via generate.
  - Inputs: `clk`, `rst`, `load`, load nibble (already clamped), `step_in` (carry/borrow in), `updown`.
  - Outputs: registered 4-bit digit and `step_out`.
  - `step_out` = `step_in` AND (digit==9 when up, digit==0 when down).
- Top level:
  - Drives digit 0 `step_in` from `en`.
  - Chains `step_out` to the next digit's `step_in`.
  - Builds `tc` from the last digit's `step_out`, plus saturation gating under `BCD_SATURATE_EN`.

## Test plan
All scenarios use DIGITS=2.
- Reset: `rst`=0 for 2 cycles with `en`=1 → `c_out`=8'h00, `tc`=0. Release `rst` with up, `en`=1 → sequence 01, 02, … 09, 10 (no hex digits).
- Up wrap: load 8'h98, then up for 2 cycles → 99 (`tc`=0), then 00 (`tc`=1). Third cycle → 01, `tc`=0.
- Down wrap: from 00, down 1 cycle → 99 with `tc`=1. Next → 98, `tc`=0. From 10, down → 09.
- Load clamp and priority:
  - `load_val`=8'h5C → 59.
  - `load`=1 with `en`=1 → loaded value, no step.
  - `rst`=0 with `load`=1 → 00.
- Hold and direction change: `en`=0 at 47 for 5 cycles → stays 47, `tc`=0. Then alternate up/down each cycle → 48, 47, 48.
- With `BCD_SATURATE_EN`: load 99, up 3 cycles → stays 99 with `tc`=1 each cycle. Load 00, down → stays 00 with `tc`=1.
